// File: rtl/led_mode_ctrl_pkg.sv
// Shared definitions for the LED mode controller: FSM state encoding and
// blink half-period arithmetic.
package led_mode_ctrl_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        S_OFF  = 2'd0,
        S_ON   = 2'd1,
        S_SLOW = 2'd2,
        S_FAST = 2'd3
    } state_t;

    // Clocks per half blink period (LED on for one half, off for the other).
    function automatic int half_period(input int clk_hz, input int blink_hz);
        return clk_hz / (2 * blink_hz);
    endfunction

endpackage

// File: rtl/sw_conditioner.sv
// Switch conditioning: 2-FF synchronizer, optional debounce, armed rising-edge
// detect. Debounce is compiled in with LED_MODE_CTRL_DEBOUNCE_EN.
module sw_conditioner #(
    parameter int DB_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic sw,
    output logic press
);

    logic s1;
    logic s2;
    logic live;
    logic armed;
    logic q;
    logic q_d;

    if (DB_CYCLES < 1) begin : g_bad_db
        $error("sw_conditioner: DB_CYCLES must be >= 1");
    end

`ifdef LED_MODE_CTRL_DEBOUNCE_EN
    localparam int DB_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_TC = DB_W'(DB_CYCLES - 1);

    logic [DB_W-1:0] dcnt;
    logic            stable;

    // stable only follows s2 after DB_CYCLES consecutive mismatching cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            dcnt   <= '0;
            stable <= 1'b0;
        end else if (s2 == stable) begin
            dcnt <= '0;
        end else if (dcnt == DB_TC) begin
            stable <= s2;
            dcnt   <= '0;
        end else begin
            dcnt <= dcnt + DB_W'(1);
        end
    end

    assign q = stable;
`else
    assign q = s2;
`endif

    // live marks that s1 holds a real post-reset sample, so the reset-zero
    // contents of the sync chain cannot arm the detector for a held switch.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            live  <= 1'b0;
            armed <= 1'b0;
            q_d   <= 1'b0;
        end else begin
            s1    <= sw;
            s2    <= s1;
            live  <= 1'b1;
            armed <= armed | (live & ~s1 & ~s2 & ~q);
            q_d   <= q;
        end
    end

    // press is a single-cycle pulse; the consumer acts on it the same cycle.
    assign press = q & ~q_d & armed;

endmodule

// File: rtl/led_mode_ctrl.sv
// LED mode controller: each switch press steps OFF -> ON -> BLINK_SLOW ->
// BLINK_FAST -> OFF. Optional debounce via LED_MODE_CTRL_DEBOUNCE_EN.
module led_mode_ctrl
    import led_mode_ctrl_pkg::*;
#(
    parameter int CLK_HZ    = 100_000_000,
    parameter int SLOW_HZ   = 1,
    parameter int FAST_HZ   = 4,
    parameter int DB_CYCLES = 1_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sw,
    output logic       led,
    output logic [1:0] mode
);

    localparam int HALF_SLOW = half_period(CLK_HZ, SLOW_HZ);
    localparam int HALF_FAST = half_period(CLK_HZ, FAST_HZ);
    localparam int CNT_W     = (HALF_SLOW > 1) ? $clog2(HALF_SLOW) : 1;
    localparam logic [CNT_W-1:0] SLOW_TC = CNT_W'(HALF_SLOW - 1);
    localparam logic [CNT_W-1:0] FAST_TC = CNT_W'(HALF_FAST - 1);

    if (FAST_HZ <= SLOW_HZ || HALF_FAST < 1) begin : g_bad_rates
        $error("led_mode_ctrl: need FAST_HZ > SLOW_HZ and HALF_FAST >= 1");
    end

    logic             press;
    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             phase, phase_n;

    sw_conditioner #(
        .DB_CYCLES (DB_CYCLES)
    ) u_cond (
        .clk   (clk),
        .reset (reset),
        .sw    (sw),
        .press (press)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_OFF;
            cnt   <= '0;
            phase <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            phase <= phase_n;
        end
    end

    // A press takes priority over the blink terminal count.
    always_comb begin
        state_n = state;
        cnt_n   = '0;
        phase_n = 1'b0;
        if (press) begin
            state_n = state_t'(state + 2'd1);
            if (state_n == S_SLOW || state_n == S_FAST) begin
                phase_n = 1'b1;
            end
        end else if (state == S_SLOW || state == S_FAST) begin
            phase_n = phase;
            if (cnt == ((state == S_SLOW) ? SLOW_TC : FAST_TC)) begin
                phase_n = ~phase;
            end else begin
                cnt_n = cnt + CNT_W'(1);
            end
        end
    end

    assign led  = (state == S_ON) | (((state == S_SLOW) | (state == S_FAST)) & phase);
    assign mode = state;

endmodule

// File: tb/tb_led_mode_ctrl.sv
// Bench for led_mode_ctrl at CLK_HZ=20, SLOW_HZ=2, FAST_HZ=5, DB_CYCLES=4;
// build with LED_MODE_CTRL_DEBOUNCE_EN to cover the debounced variant.
`timescale 1ns/1ps
module tb_led_mode_ctrl;

    localparam int CLK_HZ    = 20;
    localparam int SLOW_HZ   = 2;
    localparam int FAST_HZ   = 5;
    localparam int DB_CYCLES = 4;
    localparam int HALF_S    = 5;
    localparam int HALF_F    = 2;
`ifdef LED_MODE_CTRL_DEBOUNCE_EN
    localparam int LAT       = 7;
    localparam int HOLD      = 10;
    localparam int LOW_SLOW  = 16;
    localparam int LOW_REL   = 8;
`else
    localparam int LAT       = 3;
    localparam int HOLD      = 3;
    localparam int LOW_SLOW  = 13;
    localparam int LOW_REL   = 3;
`endif

    // ---------------- clock / reset ----------------
    logic       clk   = 1'b0;
    logic       reset = 1'b0;
    logic       sw    = 1'b0;
    logic       led;
    logic [1:0] mode;

    always #5 clk = ~clk;

    led_mode_ctrl #(
        .CLK_HZ    (CLK_HZ),
        .SLOW_HZ   (SLOW_HZ),
        .FAST_HZ   (FAST_HZ),
        .DB_CYCLES (DB_CYCLES)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .sw    (sw),
        .led   (led),
        .mode  (mode)
    );

    // ---------------- scoreboard state ----------------
    logic [2:0] exp_q[$];
    logic [2:0] e;
    int total    = 0;
    int bad      = 0;
    int cyc      = 0;
    int cur_mode = 0;
    int k        = 0;

    // LED level k cycles after entering mode m (k=0 is the entry cycle).
    function automatic logic exp_led(input int m, input int kk);
        if (m == 1) return 1'b1;
        if (m == 2) return ((kk / HALF_S) % 2) == 0;
        if (m == 3) return ((kk / HALF_F) % 2) == 0;
        return 1'b0;
    endfunction

    // ---------------- driver tasks ----------------
    // One clock: drive sw, and queue the expected {mode,led} after the edge.
    task automatic step(input logic v, input bit chg);
        @(negedge clk);
        reset = 1'b0;
        sw    = v;
        if (chg) begin
            cur_mode = (cur_mode + 1) % 4;
            k        = 0;
        end else begin
            k++;
        end
        exp_q.push_back({2'(cur_mode), exp_led(cur_mode, k)});
    endtask

    task automatic idle(input int n, input logic v);
        for (int i = 0; i < n; i++) step(v, 1'b0);
    endtask

    // sw high for hold cycles then low; the mode lands LAT edges after the rise.
    task automatic press_sw(input int hold, input int low);
        for (int i = 0; i < hold + low; i++) step(i < hold, i == LAT - 1);
    endtask

    task automatic do_reset(input int n, input logic v);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            reset    = 1'b1;
            sw       = v;
            cur_mode = 0;
            k        = 0;
            exp_q.push_back(3'b000);
        end
    endtask

    // ---------------- monitor ----------------
    initial begin
        forever begin
            @(posedge clk);
            #2;
            cyc++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                total++;
                if ({mode, led} !== e) begin
                    bad++;
                    $display("FAIL out_chk cyc=%0d got mode=%0d led=%0b want mode=%0d led=%0b",
                             cyc, mode, led, e[2:1], e[0]);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        // reset then idle
        do_reset(2, 1'b0);
        idle(20, 1'b0);

        // full cycle 0->1->2->3->0; FAST entered while slow phase is low
        press_sw(HOLD, 10);
        press_sw(HOLD, LOW_SLOW);
        press_sw(HOLD, 12);
        press_sw(HOLD, 10);

`ifdef LED_MODE_CTRL_DEBOUNCE_EN
        // short glitches are absorbed
        for (int g = 0; g < 2; g++) begin
            step(1'b1, 1'b0);
            step(1'b1, 1'b0);
            idle(8, 1'b0);
        end
`endif

        // reach S_FAST, reset mid-blink, then step once more
        press_sw(HOLD, 10);
        press_sw(HOLD, 10);
        press_sw(HOLD, 7);
        do_reset(1, 1'b0);
        idle(4, 1'b0);
        press_sw(HOLD, 10);

        // switch held through reset gives no press until released
        do_reset(2, 1'b1);
        idle(12, 1'b1);
        idle(LOW_REL, 1'b0);
        press_sw(HOLD, 10);

        @(posedge clk);
        #3;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain got %0d left want 0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
